// File: rtl/mux_real_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_real_pkg
//  Description : Shared helpers for fixed-point real-format blocks: exponent
//                alignment shift, intermediate width and saturation limits.
//  Revision    : 1.0  initial release
// ============================================================================
package mux_real_pkg;

    // Upper and lower clamp values for a signed output of a given width
    typedef struct packed {
        logic signed [63:0] hi;
        logic signed [63:0] lo;
    } sat_limits_t;

    function automatic int max0(input int d);
        return (d > 0) ? d : 0;
    endfunction

    // Width needed to hold the aligned value without losing any bits
    function automatic int inter_width(input int w_in, input int d);
        return w_in + max0(d);
    endfunction

    // Positive d scales up; negative d is an arithmetic shift (floor toward -inf)
    function automatic longint align_shift(input longint v, input int d);
        if (d >= 0)
            return v <<< d;
        else
            return v >>> (-d);
    endfunction

    function automatic sat_limits_t sat_limits(input int w);
        sat_limits_t r;
        r.hi = (longint'(1) <<< (w - 1)) - longint'(1);
        r.lo = -(longint'(1) <<< (w - 1));
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_real_pipe_align_sat.sv
`default_nettype none
// ============================================================================
//  Module      : align_sat_real
//  Description : Combinational re-format of a signed fixed-point value from
//                exponent EXP_IN to EXP_OUT with overflow detection and
//                optional clamping. Intermediate values are carried in 64 bits,
//                so WIDTH_IN + max(EXP_IN-EXP_OUT,0) must not exceed 64.
//  Revision    : 1.0  initial release
// ============================================================================
module align_sat_real
    import mux_real_pkg::*;
#(
    parameter int WIDTH_IN  = 16,
    parameter int EXP_IN    = -8,
    parameter int WIDTH_OUT = 16,
    parameter int EXP_OUT   = -10,
    parameter int SATURATE  = 1
) (
    input  logic [WIDTH_IN-1:0]  i_raw,
    output logic [WIDTH_OUT-1:0] o_val,
    output logic                 o_ovf
);

    localparam int                 c_D     = EXP_IN - EXP_OUT;
    localparam int                 c_W_INT = inter_width(WIDTH_IN, c_D);
    localparam sat_limits_t        c_LIM   = sat_limits(WIDTH_OUT);
    localparam logic signed [63:0] c_HI    = c_LIM.hi;
    localparam logic signed [63:0] c_LO    = c_LIM.lo;

    logic signed [63:0]        w_ext;
    logic signed [c_W_INT-1:0] w_int;
    logic signed [63:0]        w_wide;
    logic                      w_ovf;

    assign w_ext  = {{(64-WIDTH_IN){i_raw[WIDTH_IN-1]}}, i_raw};
    // Intermediate result kept at full precision before the range check
    assign w_int  = c_W_INT'(align_shift(w_ext, c_D));
    assign w_wide = 64'(w_int);
    assign w_ovf  = (w_wide > c_HI) || (w_wide < c_LO);

    // Clamp toward the overflowing side, or keep the low bits (wrap)
    always_comb begin
        o_val = w_wide[WIDTH_OUT-1:0];
        if ((SATURATE != 0) && w_ovf)
            o_val = w_wide[63] ? c_LO[WIDTH_OUT-1:0] : c_HI[WIDTH_OUT-1:0];
    end

    assign o_ovf = w_ovf;

endmodule
`default_nettype wire

// File: rtl/mux_real_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mux_real_pipe
//  Description : N-channel fixed-point selector with format alignment and
//                optional saturation behind a two-stage valid/ready pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
module mux_real_pipe
    import mux_real_pkg::*;
#(
    parameter int N         = 4,
    parameter int WIDTH_IN  = 16,
    parameter int EXP_IN    = -8,
    parameter int WIDTH_OUT = 16,
    parameter int EXP_OUT   = -10,
    parameter int SATURATE  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_cke,
    input  logic [N*WIDTH_IN-1:0]   i_in_data,
    input  logic [$clog2(N)-1:0]    i_sel,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    output logic [WIDTH_OUT-1:0]    o_out,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic                    o_sat,
    output logic                    o_sel_err
);

    logic                 r_s1_valid;
    logic [WIDTH_IN-1:0]  r_s1_raw;
    logic                 r_s1_bad;
    logic [WIDTH_OUT-1:0] r_out;
    logic                 r_out_valid;
    logic                 r_sat;
    logic                 r_sel_err;

    logic                 w_s2_ready;
    logic                 w_s1_ready;
    logic                 w_accept;
    logic [WIDTH_IN-1:0]  w_raw;
    logic                 w_sel_bad;
    logic [WIDTH_OUT-1:0] w_aligned;
    logic                 w_ovf;

    // A stage may load when empty or when its contents move on this cycle
    assign w_s2_ready = !r_out_valid || i_out_ready;
    assign w_s1_ready = !r_s1_valid || w_s2_ready;
    assign o_in_ready = i_cke && w_s1_ready;
    assign w_accept   = i_in_valid && o_in_ready;

    // Channel select; indices past the last channel flag an error and read 0
    always_comb begin
        w_raw     = '0;
        w_sel_bad = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (int'(i_sel) == k) begin
                w_raw     = i_in_data[k*WIDTH_IN +: WIDTH_IN];
                w_sel_bad = 1'b0;
            end
        end
    end

    // Stage 1: capture the selected raw channel on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_raw   <= '0;
            r_s1_bad   <= 1'b0;
        end else if (i_cke && w_s1_ready) begin
            r_s1_valid <= i_in_valid;
            if (i_in_valid) begin
                r_s1_raw <= w_raw;
                r_s1_bad <= w_sel_bad;
            end
        end
    end

    align_sat_real #(
        .WIDTH_IN  (WIDTH_IN),
        .EXP_IN    (EXP_IN),
        .WIDTH_OUT (WIDTH_OUT),
        .EXP_OUT   (EXP_OUT),
        .SATURATE  (SATURATE)
    ) u_align (
        .i_raw (r_s1_raw),
        .o_val (w_aligned),
        .o_ovf (w_ovf)
    );

    // Stage 2: register the aligned result; out/sat hold when nothing advances
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_sat       <= 1'b0;
        end else if (i_cke && w_s2_ready) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out <= r_s1_bad ? '0 : w_aligned;
                r_sat <= !r_s1_bad && (SATURATE != 0) && w_ovf;
            end
        end
    end

    // Sticky out-of-range select flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_sel_err <= 1'b0;
        else if (w_accept && w_sel_bad)
            r_sel_err <= 1'b1;
    end

    assign o_out       = r_out;
    assign o_out_valid = r_out_valid;
    assign o_sat       = r_sat;
    assign o_sel_err   = r_sel_err;

endmodule
`default_nettype wire
